// File: rtl/fir_tap_sequencer_pkg.sv
// Shared constants and types for the FIR tap sequencer.
package fir_seq_pkg;

    localparam int DATA_W   = 16;
    localparam int ACC_W    = 20;
    localparam int TAPS     = 8;
    localparam int CNT_W    = 4;              // holds 0..TAPS
    localparam int FCNT_W   = $clog2(TAPS);   // holds 0..TAPS-1 zero insertions
    localparam int COEF_SUM = 36;             // sum of filter coefficients 1..8

    localparam logic [CNT_W-1:0]  FILL_FULL = CNT_W'(TAPS);
    localparam logic [FCNT_W-1:0] ZINS_LAST = FCNT_W'(TAPS - 1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } seq_state_e;

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample-in / result-out streaming bus of the FIR tap sequencer.
// Both streams use valid/ready: a beat transfers on a rising clk edge where
// valid && ready; once valid is high, the producer holds valid and data stable
// until that transfer happens, and ready may depend combinationally on valid.
interface fir_tap_sequencer_if;
    import fir_seq_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [ACC_W-1:0]  m_data;

    // Sequencer side: consumes samples, produces results.
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

    // Environment side: produces samples, consumes results.
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

endinterface

// File: rtl/fir_seq_out_slot.sv
// One-entry output register with a pending flag: a full-window advance marks
// a result as pending, and it is captured from the filter once the slot is free.
module fir_seq_out_slot
    import fir_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv_full_i,
    input  logic [ACC_W-1:0] filt_data_out_i,
    input  logic             m_ready_i,
    output logic             pend_o,
    output logic             m_valid_o,
    output logic [ACC_W-1:0] m_data_o
);

    logic             pend_q, pend_d;
    logic             m_valid_q, m_valid_d;
    logic [ACC_W-1:0] m_data_q, m_data_d;
    logic             capture;

    // Capture the filter output when a result is pending and the slot is free.
    always_comb begin
        capture   = pend_q && (!m_valid_q || m_ready_i);
        pend_d    = adv_full_i ? 1'b1 : (capture ? 1'b0 : pend_q);
        m_valid_d = capture ? 1'b1 : (m_ready_i ? 1'b0 : m_valid_q);
        m_data_d  = capture ? filt_data_out_i : m_data_q;
    end

    // Slot registers; a pending result is dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q    <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            pend_q    <= pend_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign pend_o    = pend_q;
    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;

endmodule

// File: rtl/fir_tap_sequencer.sv
// Streaming controller for the external 8-tap combinational FIR datapath.
// Keeps the sample window (tap 0 newest), drives it onto the filter and
// registers results through a one-entry valid/ready slot.
// Optional feature: define FIR_SEQ_FLUSH_EN to compile in the FLUSH state,
// which drains the window by inserting TAPS-1 zeros; otherwise flush is ignored.
module fir_tap_sequencer
    import fir_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    fir_tap_sequencer_if.slave     bus,
    input  logic                   flush,
    output logic [TAPS*DATA_W-1:0] filt_data_in,
    input  logic [ACC_W-1:0]       filt_data_out,
    output logic [CNT_W-1:0]       fill_count,
    output logic                   busy,
    output seq_state_e             state_dbg
);

    logic [DATA_W-1:0] win_q [TAPS];
    logic [CNT_W-1:0]  fill_q, fill_d;
    seq_state_e        state_q;

    logic              pend, m_valid, slot_free;
    logic              accept, advance, adv_full;
    logic              flush_go, zero_ins, win_clear;
    logic [DATA_W-1:0] adv_sample;
    logic [ACC_W-1:0]  m_data;

    // An advance is allowed only if its result can eventually be captured.
    assign slot_free = !pend || !m_valid || bus.m_ready;

`ifdef FIR_SEQ_FLUSH_EN
    logic [FCNT_W-1:0] zcnt_q;

    assign bus.s_ready = (state_q != ST_FLUSH) && !flush && slot_free;
    assign flush_go    = flush && (state_q != ST_FLUSH) && (fill_q != '0);
    assign zero_ins    = (state_q == ST_FLUSH) && (zcnt_q != ZINS_LAST) && slot_free;
    assign win_clear   = (state_q == ST_FLUSH) && (zcnt_q == ZINS_LAST) && !pend;

    // Count zero insertions of the current flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zcnt_q <= '0;
        end else if (flush_go) begin
            zcnt_q <= '0;
        end else if (zero_ins) begin
            zcnt_q <= zcnt_q + 1'b1;
        end
    end
`else
    logic unused_flush;

    assign unused_flush = flush;
    assign bus.s_ready  = slot_free;
    assign flush_go     = 1'b0;
    assign zero_ins     = 1'b0;
    assign win_clear    = 1'b0;
`endif

    // Advance decode: accepted sample or an internal zero, saturating fill count.
    always_comb begin
        accept     = bus.s_valid && bus.s_ready;
        advance    = accept || zero_ins;
        adv_sample = accept ? bus.s_data : '0;
        fill_d     = (advance && (fill_q != FILL_FULL)) ? fill_q + 1'b1 : fill_q;
        adv_full   = advance && (fill_d == FILL_FULL);
    end

    // Window, fill count and control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) win_q[k] <= '0;
            fill_q  <= '0;
            state_q <= ST_FILL;
        end else begin
            if (win_clear) begin
                for (int k = 0; k < TAPS; k++) win_q[k] <= '0;
                fill_q <= '0;
            end else begin
                if (advance) begin
                    for (int k = TAPS - 1; k > 0; k--) win_q[k] <= win_q[k-1];
                    win_q[0] <= adv_sample;
                end
                fill_q <= fill_d;
            end
            unique case (state_q)
                ST_FILL: begin
                    if (flush_go)      state_q <= ST_FLUSH;
                    else if (adv_full) state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (flush_go) state_q <= ST_FLUSH;
                end
                default: begin
                    if (win_clear) state_q <= ST_FILL;
                end
            endcase
        end
    end

    fir_seq_out_slot u_slot (
        .clk             (clk),
        .rst_n           (rst_n),
        .adv_full_i      (adv_full),
        .filt_data_out_i (filt_data_out),
        .m_ready_i       (bus.m_ready),
        .pend_o          (pend),
        .m_valid_o       (m_valid),
        .m_data_o        (m_data)
    );

    for (genvar k = 0; k < TAPS; k++) begin : g_taps
        assign filt_data_in[k*DATA_W +: DATA_W] = win_q[k];
    end

    assign bus.m_valid = m_valid;
    assign bus.m_data  = m_data;
    assign fill_count  = fill_q;
    assign busy        = (state_q != ST_FILL) || (fill_q != '0) || pend || m_valid;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with a behavioural filter (coefficients 1..8).
module tb_fir_tap_sequencer;
    import fir_seq_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   flush = 1'b0;
    logic [TAPS*DATA_W-1:0] filt_data_in;
    logic [ACC_W-1:0]       filt_data_out;
    logic [CNT_W-1:0]       fill_count;
    logic                   busy;
    seq_state_e             state_dbg;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out;
    logic [ACC_W-1:0] exp_q[$];

    fir_tap_sequencer_if bus();

    fir_tap_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .flush         (flush),
        .filt_data_in  (filt_data_in),
        .filt_data_out (filt_data_out),
        .fill_count    (fill_count),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Filter model: out = sum (k+1) * tap[k], mod 2^ACC_W
    always_comb begin
        filt_data_out = '0;
        for (int k = 0; k < TAPS; k++)
            filt_data_out = filt_data_out
                          + ACC_W'(k + 1) * ACC_W'(filt_data_in[k*DATA_W +: DATA_W]);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic feed_ramp();
        for (int i = 1; i <= TAPS; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = DATA_W'(i);
            cyc();
        end
        bus.s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;

        // Reset state
        repeat (2) cyc();
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_m_data", 32'(bus.m_data), 0);
        chk("rst_fill", 32'(fill_count), 0);
        chk("rst_s_ready", 32'(bus.s_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_state", 32'(state_dbg), 32'(ST_FILL));
        rst_n = 1'b1;
        cyc();

        // Ramp 1..8: no output while the window is partial
        for (int i = 1; i <= TAPS; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = DATA_W'(i);
            cyc();
            chk("partial_no_out", 32'(bus.m_valid), 0);
        end
        chk("ramp_fill", 32'(fill_count), 8);
        chk("ramp_state", 32'(state_dbg), 32'(ST_RUN));
        bus.s_data = 16'd9;
        cyc();
        chk("first_valid", 32'(bus.m_valid), 1);
        chk("first_data", 32'(bus.m_data), 120);
        bus.s_data = 16'd10;
        cyc();
        chk("b2b_valid", 32'(bus.m_valid), 1);
        chk("b2b_data9", 32'(bus.m_data), 120 + COEF_SUM);
        bus.s_valid = 1'b0;
        cyc();
        chk("b2b_data10", 32'(bus.m_data), 192);
        cyc();
        chk("drained_valid", 32'(bus.m_valid), 0);

        // All-ones window wraps mod 2^20
        bus.s_valid = 1'b1;
        bus.s_data  = 16'hFFFF;
        repeat (TAPS) cyc();
        bus.s_valid = 1'b0;
        cyc();
        chk("wrap_data", 32'(bus.m_data), 262108);
        cyc();
        chk("wrap_drained", 32'(bus.m_valid), 0);

        // Backpressure: one held, one pending, then s_ready drops
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'd0;
        #1;
        chk("bp_ready0", 32'(bus.s_ready), 1);
        cyc();
        chk("bp_valid1", 32'(bus.m_valid), 0);
        chk("bp_ready1", 32'(bus.s_ready), 1);
        cyc();
        chk("bp_valid2", 32'(bus.m_valid), 1);
        chk("bp_data2", 32'(bus.m_data), 196573);
        chk("bp_ready2", 32'(bus.s_ready), 0);
        cyc();
        chk("bp_hold_valid", 32'(bus.m_valid), 1);
        chk("bp_hold_data", 32'(bus.m_data), 196573);
        chk("bp_hold_ready", 32'(bus.s_ready), 0);
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b0;
        cyc();
        chk("bp_second_valid", 32'(bus.m_valid), 1);
        chk("bp_second_data", 32'(bus.m_data), 65503);
        cyc();
        chk("bp_done", 32'(bus.m_valid), 0);

`ifdef FIR_SEQ_FLUSH_EN
        // Flush with a concurrent sample: sample rejected, 7 outputs, back to FILL
        feed_ramp();
        flush       = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'd99;
        #1;
        chk("flush_rejects", 32'(bus.s_ready), 0);
        cyc();
        flush       = 1'b0;
        bus.s_valid = 1'b0;
        chk("flush_last_run", 32'(bus.m_data), 120);
        chk("flush_state", 32'(state_dbg), 32'(ST_FLUSH));
        chk("flush_fill", 32'(fill_count), 8);
        exp_q = '{147, 164, 170, 164, 145, 112, 64};
        n_out = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (bus.m_valid) begin
                n_out++;
                if (exp_q.size() > 0) chk("flush_out", 32'(bus.m_data), 32'(exp_q.pop_front()));
            end
        end
        chk("flush_count", 32'(n_out), 7);
        chk("flush_end_state", 32'(state_dbg), 32'(ST_FILL));
        chk("flush_end_fill", 32'(fill_count), 0);
        chk("flush_end_busy", 32'(busy), 0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        cyc();
        chk("flush_empty_ignored", 32'(state_dbg), 32'(ST_FILL));
`else
        // Flush is ignored: sample accepted, state unchanged
        flush       = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'd99;
        #1;
        chk("noflush_ready", 32'(bus.s_ready), 1);
        cyc();
        flush       = 1'b0;
        bus.s_valid = 1'b0;
        chk("noflush_state", 32'(state_dbg), 32'(ST_RUN));
        chk("noflush_fill", 32'(fill_count), 8);
        cyc();
`endif

        // Async reset mid-stream drops the held result
        feed_ramp();
        bus.m_ready = 1'b0;
        cyc();
        chk("pre_rst_valid", 32'(bus.m_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.m_valid), 0);
        chk("mid_rst_data", 32'(bus.m_data), 0);
        chk("mid_rst_fill", 32'(fill_count), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        cyc();
        rst_n       = 1'b1;
        bus.m_ready = 1'b1;
        cyc();
        feed_ramp();
        cyc();
        chk("post_rst_valid", 32'(bus.m_valid), 1);
        chk("post_rst_data", 32'(bus.m_data), 120);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
